// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light slice: timer states and sizing
// used by the light FSM, the phase timer and the display driver.
package traffic_pkg;

    localparam int TIMER_WIDTH = 8;
    localparam int BCD_DIGITS  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_t;

    // The timer counts as "running" while a phase is counting or frozen.
    function automatic logic timer_active(input timer_state_t st);
        return (st == ST_RUN) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Combinational binary to packed-BCD converter (shift-and-add-3).
// Ones digit lands in bcd[3:0]; unused upper digit bits stay 0.
module bin2bcd #(
    parameter int WIDTH  = traffic_pkg::TIMER_WIDTH,
    parameter int DIGITS = traffic_pkg::BCD_DIGITS
) (
    input  logic [WIDTH-1:0]    bin,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int TOTAL = WIDTH + 4 * DIGITS;

    logic [TOTAL-1:0] shift_s;

    // Double dabble: correct each digit >= 5 before every left shift.
    always_comb begin
        shift_s = {{(4 * DIGITS){1'b0}}, bin};
        for (int i = 0; i < WIDTH; i++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (shift_s[WIDTH + 4 * d +: 4] >= 4'd5) begin
                    shift_s[WIDTH + 4 * d +: 4] = shift_s[WIDTH + 4 * d +: 4] + 4'd3;
                end else begin
                    shift_s[WIDTH + 4 * d +: 4] = shift_s[WIDTH + 4 * d +: 4];
                end
            end
            shift_s = {shift_s[TOTAL-2:0], 1'b0};
        end
        bcd = shift_s[TOTAL-1:WIDTH];
    end

endmodule

// File: rtl/phase_countdown_timer.sv
// Per-phase countdown timer for the traffic-light FSM: loads a preset,
// counts down once per second and emits a single-cycle time_up pulse.
module phase_countdown_timer #(
    parameter int WIDTH      = traffic_pkg::TIMER_WIDTH,
    parameter int BCD_DIGITS = traffic_pkg::BCD_DIGITS
) (
    input  logic                    clk_1hz,
    input  logic                    reset_n,
    input  logic                    load_timer,
    input  logic [WIDTH-1:0]        timer_preset,
    input  logic                    hold,
    output logic                    time_up,
    output logic                    running,
    output logic [WIDTH-1:0]        count,
    output logic [4*BCD_DIGITS-1:0] bcd_digits
);

    import traffic_pkg::*;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    timer_state_t     state_r;
    logic [WIDTH-1:0] count_r;
    logic             time_up_r;
    logic             running_r;

    // Phase state machine; load outranks every state-specific action.
    always_ff @(posedge clk_1hz or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            count_r   <= CNT_ZERO;
            time_up_r <= 1'b0;
            running_r <= 1'b0;
        end else if (load_timer) begin
            count_r <= timer_preset;
            if (timer_preset != CNT_ZERO) begin
                state_r   <= hold ? ST_HOLD : ST_RUN;
                time_up_r <= 1'b0;
                running_r <= 1'b1;
            end else begin
                // Zero-length phase still advances the FSM exactly once.
                state_r   <= ST_EXPIRED;
                time_up_r <= 1'b1;
                running_r <= 1'b0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r   <= ST_IDLE;
                    count_r   <= CNT_ZERO;
                    time_up_r <= 1'b0;
                    running_r <= 1'b0;
                end
                ST_RUN: begin
                    if (hold) begin
                        state_r   <= ST_HOLD;
                        count_r   <= count_r;
                        time_up_r <= 1'b0;
                        running_r <= 1'b1;
                    end else if (count_r > CNT_ONE) begin
                        state_r   <= ST_RUN;
                        count_r   <= count_r - CNT_ONE;
                        time_up_r <= 1'b0;
                        running_r <= 1'b1;
                    end else begin
                        state_r   <= ST_EXPIRED;
                        count_r   <= CNT_ZERO;
                        time_up_r <= 1'b1;
                        running_r <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    state_r   <= hold ? ST_HOLD : ST_RUN;
                    count_r   <= count_r;
                    time_up_r <= 1'b0;
                    running_r <= 1'b1;
                end
                ST_EXPIRED: begin
                    state_r   <= ST_EXPIRED;
                    count_r   <= CNT_ZERO;
                    time_up_r <= 1'b0;
                    running_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    count_r   <= CNT_ZERO;
                    time_up_r <= 1'b0;
                    running_r <= timer_active(ST_IDLE);
                end
            endcase
        end
    end

    assign time_up = time_up_r;
    assign running = running_r;
    assign count   = count_r;

    bin2bcd #(
        .WIDTH  (WIDTH),
        .DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .bin (count_r),
        .bcd (bcd_digits)
    );

endmodule

// File: tb/tb_phase_countdown_timer.sv
// Directed bench for phase_countdown_timer: vector table plus reset,
// idle and closed-loop light-FSM sequences.
module tb_phase_countdown_timer;

    logic        clk_1hz;
    logic        reset_n;
    logic        load_timer;
    logic [7:0]  timer_preset;
    logic        hold;
    logic        time_up;
    logic        running;
    logic [7:0]  count;
    logic [11:0] bcd_digits;

    int tests_run;
    int tests_failed;

    phase_countdown_timer #(.WIDTH(8), .BCD_DIGITS(3)) dut (
        .clk_1hz      (clk_1hz),
        .reset_n      (reset_n),
        .load_timer   (load_timer),
        .timer_preset (timer_preset),
        .hold         (hold),
        .time_up      (time_up),
        .running      (running),
        .count        (count),
        .bcd_digits   (bcd_digits)
    );

    initial clk_1hz = 1'b0;
    always #5 clk_1hz = ~clk_1hz;

    typedef struct {
        logic        load;
        logic [7:0]  preset;
        logic        hold;
        logic [7:0]  cnt;
        logic        tu;
        logic        run;
        logic [11:0] bcd;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_1hz);
        #1;
    endtask

    task automatic chk_all(input string tag, input int c, input int tu, input int run, input int bcd);
        chk({tag, " count"}, int'(count), c);
        chk({tag, " time_up"}, int'(time_up), tu);
        chk({tag, " running"}, int'(running), run);
        chk({tag, " bcd"}, int'(bcd_digits), bcd);
    endtask

    int presets [4];
    int light, phase_light, last_load, tu_in, phases;
    logic prev_tu, was_load;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        load_timer   = 1'b0;
        timer_preset = 8'd0;
        hold         = 1'b0;

        // load, preset, hold -> count, time_up, running, bcd (after the edge)
        vecs[0]  = '{1'b1, 8'd5,   1'b0, 8'd5,   1'b0, 1'b1, 12'h005};
        vecs[1]  = '{1'b0, 8'd0,   1'b0, 8'd4,   1'b0, 1'b1, 12'h004};
        vecs[2]  = '{1'b0, 8'd0,   1'b0, 8'd3,   1'b0, 1'b1, 12'h003};
        vecs[3]  = '{1'b0, 8'd0,   1'b0, 8'd2,   1'b0, 1'b1, 12'h002};
        vecs[4]  = '{1'b0, 8'd0,   1'b0, 8'd1,   1'b0, 1'b1, 12'h001};
        vecs[5]  = '{1'b0, 8'd0,   1'b0, 8'd0,   1'b1, 1'b0, 12'h000};
        vecs[6]  = '{1'b0, 8'd0,   1'b0, 8'd0,   1'b0, 1'b0, 12'h000};
        vecs[7]  = '{1'b0, 8'd0,   1'b0, 8'd0,   1'b0, 1'b0, 12'h000};
        vecs[8]  = '{1'b1, 8'd0,   1'b0, 8'd0,   1'b1, 1'b0, 12'h000};
        vecs[9]  = '{1'b0, 8'd0,   1'b0, 8'd0,   1'b0, 1'b0, 12'h000};
        vecs[10] = '{1'b1, 8'd4,   1'b0, 8'd4,   1'b0, 1'b1, 12'h004};
        vecs[11] = '{1'b0, 8'd0,   1'b0, 8'd3,   1'b0, 1'b1, 12'h003};
        vecs[12] = '{1'b0, 8'd0,   1'b1, 8'd3,   1'b0, 1'b1, 12'h003};
        vecs[13] = '{1'b0, 8'd0,   1'b1, 8'd3,   1'b0, 1'b1, 12'h003};
        vecs[14] = '{1'b0, 8'd0,   1'b1, 8'd3,   1'b0, 1'b1, 12'h003};
        vecs[15] = '{1'b0, 8'd0,   1'b0, 8'd3,   1'b0, 1'b1, 12'h003};
        vecs[16] = '{1'b0, 8'd0,   1'b0, 8'd2,   1'b0, 1'b1, 12'h002};
        vecs[17] = '{1'b0, 8'd0,   1'b0, 8'd1,   1'b0, 1'b1, 12'h001};
        vecs[18] = '{1'b0, 8'd0,   1'b0, 8'd0,   1'b1, 1'b0, 12'h000};
        vecs[19] = '{1'b0, 8'd0,   1'b0, 8'd0,   1'b0, 1'b0, 12'h000};
        vecs[20] = '{1'b1, 8'd1,   1'b0, 8'd1,   1'b0, 1'b1, 12'h001};
        vecs[21] = '{1'b1, 8'd200, 1'b0, 8'd200, 1'b0, 1'b1, 12'h200};
        vecs[22] = '{1'b0, 8'd0,   1'b0, 8'd199, 1'b0, 1'b1, 12'h199};
        vecs[23] = '{1'b1, 8'd255, 1'b0, 8'd255, 1'b0, 1'b1, 12'h255};
        vecs[24] = '{1'b1, 8'd1,   1'b1, 8'd1,   1'b0, 1'b1, 12'h001};
        vecs[25] = '{1'b0, 8'd0,   1'b0, 8'd1,   1'b0, 1'b1, 12'h001};
        vecs[26] = '{1'b0, 8'd0,   1'b0, 8'd0,   1'b1, 1'b0, 12'h000};

        // Reset held from time 0, then an idle stretch with no load.
        #2;
        chk_all("reset", 0, 0, 0, 0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle[%0d] time_up", i), int'(time_up), 0);
            chk($sformatf("idle[%0d] running", i), int'(running), 0);
            chk($sformatf("idle[%0d] count", i), int'(count), 0);
        end

        for (int v = 0; v < NVEC; v++) begin
            load_timer   = vecs[v].load;
            timer_preset = vecs[v].preset;
            hold         = vecs[v].hold;
            step();
            chk_all($sformatf("vec[%0d]", v), int'(vecs[v].cnt), int'(vecs[v].tu),
                    int'(vecs[v].run), int'(vecs[v].bcd));
        end

        // Asynchronous reset in the middle of a countdown.
        load_timer   = 1'b1;
        timer_preset = 8'd50;
        hold         = 1'b0;
        step();
        load_timer = 1'b0;
        step();
        chk("pre-reset count", int'(count), 49);
        #3 reset_n = 1'b0;
        #1;
        chk_all("async reset", 0, 0, 0, 0);
        step();
        reset_n = 1'b1;
        step();
        step();
        chk_all("post-reset idle", 0, 0, 0, 0);
        load_timer   = 1'b1;
        timer_preset = 8'd2;
        step();
        load_timer = 1'b0;
        chk_all("fresh load", 2, 0, 1, 2);
        step();
        chk_all("fresh 1", 1, 0, 1, 1);
        step();
        chk_all("fresh expire", 0, 1, 0, 0);

        // Closed loop with a light-FSM model whose load lags time_up by one edge.
        presets[0] = 3; presets[1] = 1; presets[2] = 3; presets[3] = 1;
        light        = 0;
        phase_light  = 0;
        load_timer   = 1'b1;
        timer_preset = 8'd3;
        step();
        chk("loop first load", int'(count), 3);
        load_timer = 1'b0;
        last_load  = 0;
        tu_in      = 0;
        phases     = 0;
        prev_tu    = time_up;
        for (int e = 1; e <= 60 && phases < 8; e++) begin
            was_load = load_timer;
            step();
            if (was_load) begin
                chk($sformatf("loop phase %0d length", phases), e - last_load,
                    presets[phase_light] + 2);
                chk($sformatf("loop phase %0d pulses", phases), tu_in, 1);
                chk($sformatf("loop phase %0d load", phases), int'(count), presets[light]);
                last_load   = e;
                tu_in       = 0;
                phase_light = light;
                phases++;
            end
            if (time_up) tu_in++;
            load_timer = prev_tu;
            if (prev_tu) begin
                light        = (light + 1) % 4;
                timer_preset = 8'(presets[light]);
            end
            prev_tu = time_up;
        end
        chk("loop phases completed", phases, 8);
        chk("loop light wrapped", light, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
